// File: rtl/cpu_generic_pkg.sv
// Shared definitions for the generic 8-register CPU: FSM states, opcode
// class patterns (instruction bits [15:11]) and ALU operation codes.
package cpu_generic_pkg;

  typedef enum logic [2:0] {
    S_RESET,
    S_SELECT,
    S_DECODE,
    S_COMPUTE,
    S_LOAD,
    S_STORE
  } state_t;

  // Opcode class, instruction bits [15:11]
  localparam logic [4:0] OP_ALU = 5'b00000;  // 00000aaa 0ppppbbb
  localparam logic [4:0] OP_BR  = 5'b00001;  // 00001ttt imm8
  localparam logic [4:0] OP_LI  = 5'b00100;  // 00100aaa imm8
  localparam logic [4:0] OP_LD  = 5'b00101;  // 00101aaa imm8
  localparam logic [4:0] OP_ST  = 5'b00110;  // 00110aaa imm8
  localparam logic [4:0] OP_LDX = 5'b01000;  // 01000aaa iiiiibbb
  localparam logic [4:0] OP_STX = 5'b01010;  // 01010aaa iiiiibbb

  // ALU operations; bit 2 set marks the ops whose carry-out updates the carry flag
  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_XOR = 4'h2;
  localparam logic [3:0] ALU_MOV = 4'h3;  // Y = b
  localparam logic [3:0] ALU_ADD = 4'h4;
  localparam logic [3:0] ALU_SUB = 4'h5;  // carry = borrow
  localparam logic [3:0] ALU_ADC = 4'h6;
  localparam logic [3:0] ALU_SHL = 4'h7;  // carry = a[MSB]

endpackage

// File: rtl/cpu_generic_if.sv
// Memory bus of the generic CPU.
//   address  : CPU -> memory, registered address
//   data_out : CPU -> memory, store data
//   write    : CPU -> memory, store strobe
//   data_in  : memory -> CPU, read data (combinational from address)
//   ready    : memory -> CPU, 0 stalls the current fetch/load/store
interface cpu_generic_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] address;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             write;
  logic             ready;

  modport master (output address, data_out, write, input data_in, ready);
  modport slave  (input address, data_out, write, output data_in, ready);
endinterface

// File: rtl/cpu_generic_alu.sv
// Combinational ALU of the generic CPU.
//   op       : operation code (ALU_* in cpu_generic_pkg)
//   a, b     : operands
//   carry_in : current carry flag (used by ADC)
//   y        : WIDTH+1 bit result, y[WIDTH] is the carry/borrow out
module cpu_generic_alu
  import cpu_generic_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH:0]   y
);

  always_comb begin
    y = {1'b0, a};
    case (op)
      ALU_AND: y = {1'b0, a & b};
      ALU_OR:  y = {1'b0, a | b};
      ALU_XOR: y = {1'b0, a ^ b};
      ALU_MOV: y = {1'b0, b};
      ALU_ADD: y = {1'b0, a} + {1'b0, b};
      ALU_SUB: y = {1'b0, a} - {1'b0, b};
      ALU_ADC: y = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
      ALU_SHL: y = {a, 1'b0};
      default: y = {1'b0, a};
    endcase
  end

endmodule

// File: rtl/cpu_generic.sv
// Generic multi-cycle CPU: eight WIDTH-bit registers (r7 is the instruction
// pointer), carry/zero/neg flags, one memory bus shared by fetch, load, store.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : memory master port (address, data_out, write, data_in, ready)
module cpu_generic
  import cpu_generic_pkg::*;
#(
  parameter int unsigned      WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic          clk,
  input  logic          reset,
  cpu_generic_if.master bus
);

  state_t           state;
  logic [WIDTH-1:0] regs [8];
  logic             carry, zero, neg;
  logic [3:0]       aluop;
  logic [2:0]       ra, rb;
  logic [WIDTH:0]   alu_y;

  // Instruction fields; only the low 16 bits of data_in carry an opcode
  logic [15:0]      op;
  logic [4:0]       op_class;
  logic [2:0]       op_a, op_b;
  logic [WIDTH-1:0] imm_z, imm_s, idx_addr;
  logic             br_take;

  assign op       = bus.data_in[15:0];
  assign op_class = op[15:11];
  assign op_a     = op[10:8];
  assign op_b     = op[2:0];
  assign imm_z    = {{(WIDTH-8){1'b0}}, op[7:0]};
  assign imm_s    = {{(WIDTH-8){op[7]}}, op[7:0]};
  assign idx_addr = regs[op_b] + {{(WIDTH-5){1'b0}}, op[7:3]};
  // ttt = {t2, t1, t0}: t2 is the flag value the branch waits for
  assign br_take  = (op[8] && (carry == op[10])) || (op[9] && (zero == op[10]));

  cpu_generic_alu #(.WIDTH(WIDTH)) u_alu (
    .op       (aluop),
    .a        (regs[ra]),
    .b        (regs[rb]),
    .carry_in (carry),
    .y        (alu_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_RESET;
      bus.write    <= 1'b0;
      bus.address  <= '0;
      bus.data_out <= '0;
      carry        <= 1'b0;
      zero         <= 1'b0;
      neg          <= 1'b0;
    end else begin
      case (state)
        S_RESET: begin
          regs[7]   <= RESET_VECTOR;
          bus.write <= 1'b0;
          state     <= S_SELECT;
        end

        S_SELECT: begin
          bus.address <= regs[7];
          regs[7]     <= regs[7] + WIDTH'(1);
          bus.write   <= 1'b0;
          state       <= S_DECODE;
        end

        S_DECODE: begin
          if (bus.ready) begin
            ra    <= op_a;
            rb    <= op_b;
            state <= S_SELECT;
            case (op_class)
              OP_ALU: begin
                if (!op[7]) begin
                  aluop <= op[6:3];
                  state <= S_COMPUTE;
                end else begin
                  state <= S_RESET;
                end
              end
              OP_BR: begin
                // regs[7] already points past this instruction
                if (br_take) regs[7] <= regs[7] + imm_s;
              end
              OP_LI: regs[op_a] <= imm_z;
              OP_LD: begin
                bus.address <= imm_z;
                state       <= S_LOAD;
              end
              OP_LDX: begin
                bus.address <= idx_addr;
                state       <= S_LOAD;
              end
              OP_ST: begin
                bus.address  <= imm_z;
                bus.data_out <= regs[op_a];
                bus.write    <= 1'b1;
                state        <= S_STORE;
              end
              OP_STX: begin
                bus.address  <= idx_addr;
                bus.data_out <= regs[op_a];
                bus.write    <= 1'b1;
                state        <= S_STORE;
              end
              default: state <= S_RESET;
            endcase
          end
        end

        S_COMPUTE: begin
          regs[ra] <= alu_y[WIDTH-1:0];
          zero     <= ~|alu_y[WIDTH-1:0];
          neg      <= alu_y[WIDTH-1];
          if (aluop[2]) carry <= alu_y[WIDTH];
          state    <= S_SELECT;
        end

        S_LOAD: begin
          if (bus.ready) begin
            regs[ra] <= bus.data_in;
            zero     <= ~|bus.data_in;
            neg      <= bus.data_in[WIDTH-1];
            state    <= S_SELECT;
          end
        end

        S_STORE: begin
          if (bus.ready) begin
            bus.write <= 1'b0;
            state     <= S_SELECT;
          end
        end

        default: state <= S_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_generic.sv
// Directed bench for cpu_generic at WIDTH=16: ROM at 0x8000.., RAM below,
// stores checked against a queue of expected (address, data) pairs.
module tb_cpu_generic;

  localparam logic [3:0] A_OR  = 4'h1;
  localparam logic [3:0] A_MOV = 4'h3;
  localparam logic [3:0] A_ADD = 4'h4;
  localparam logic [3:0] A_SUB = 4'h5;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } st_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_generic_if #(.WIDTH(16)) bus ();

  cpu_generic #(.WIDTH(16), .RESET_VECTOR(16'h8000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] rom [256];
  logic [15:0] ram [256];
  assign bus.data_in = bus.address[15] ? rom[bus.address[7:0]] : ram[bus.address[7:0]];

  st_t         sb [$];
  int unsigned n_pass, n_total;
  int unsigned pc;

  function automatic logic [15:0] i_alu(input logic [2:0] a, input logic [3:0] p, input logic [2:0] b);
    return {5'b00000, a, 1'b0, p, b};
  endfunction
  function automatic logic [15:0] i_br(input logic [2:0] t, input logic [7:0] off);
    return {5'b00001, t, off};
  endfunction
  function automatic logic [15:0] i_li(input logic [2:0] a, input logic [7:0] imm);
    return {5'b00100, a, imm};
  endfunction
  function automatic logic [15:0] i_ld(input logic [2:0] a, input logic [7:0] imm);
    return {5'b00101, a, imm};
  endfunction
  function automatic logic [15:0] i_st(input logic [2:0] a, input logic [7:0] imm);
    return {5'b00110, a, imm};
  endfunction
  function automatic logic [15:0] i_ldx(input logic [2:0] a, input logic [4:0] i5, input logic [2:0] b);
    return {5'b01000, a, i5, b};
  endfunction
  function automatic logic [15:0] i_stx(input logic [2:0] a, input logic [4:0] i5, input logic [2:0] b);
    return {5'b01010, a, i5, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic put(input logic [15:0] ins);
    rom[pc[7:0]] = ins;
    pc++;
  endtask

  task automatic expect_st(input logic [15:0] a, input logic [15:0] d);
    st_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // One clock: memory write and scoreboard check just before the edge,
  // outputs settled 1 time unit after it.
  task automatic tick();
    st_t e;
    @(negedge clk);
    if (bus.write === 1'b1 && bus.ready === 1'b1) begin
      if (!bus.address[15]) ram[bus.address[7:0]] = bus.data_out;
      chk("sb_pending", (sb.size() != 0), 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_addr", bus.address, e.addr);
        chk("sb_data", bus.data_out, e.data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bus(input logic [15:0] a, input logic w, input int unsigned budget, output bit found);
    found = 1'b0;
    for (int unsigned i = 0; i < budget && !found; i++) begin
      tick();
      if (bus.address === a && bus.write === w) found = 1'b1;
    end
  endtask

  bit          found;
  int unsigned high;

  initial begin
    n_pass    = 0;
    n_total   = 0;
    reset     = 1'b1;
    bus.ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'hFFFF;
      ram[i] = 16'h0000;
    end
    ram[8'h40] = 16'h1234;

    pc = 0;
    put(i_li(0, 8'h05));                     // 0
    put(i_li(1, 8'h03));                     // 1
    put(i_alu(0, A_ADD, 1));                 // 2  r0 = 8
    put(i_st(0, 8'h20));                     // 3
    expect_st(16'h0020, 16'h0008);
    put(i_ld(2, 8'h40));                     // 4  r2 = 0x1234
    put(i_li(1, 8'h10));                     // 5
    put(i_stx(2, 5'd3, 1));                  // 6  [0x13] = 0x1234, stalled
    expect_st(16'h0013, 16'h1234);
    put(i_ldx(4, 5'd3, 1));                  // 7  r4 = [0x13]
    put(i_st(4, 8'h21));                     // 8
    expect_st(16'h0021, 16'h1234);
    put(i_li(5, 8'h80));                     // 9
    for (int i = 0; i < 8; i++) put(i_alu(5, A_ADD, 5));  // 10..17 r5 = 0x8000
    put(i_alu(6, A_MOV, 5));                 // 18 r6 = 0x8000
    put(i_alu(5, A_ADD, 5));                 // 19 r5 = 0, carry = 1, zero = 1
    put(i_st(5, 8'h22));                     // 20
    expect_st(16'h0022, 16'h0000);
    put(i_li(3, 8'h01));                     // 21 flags untouched
    put(i_br(3'b101, 8'h01));                // 22 carry==1 -> skip 23
    put(i_st(3, 8'h30));                     // 23
    put(i_br(3'b010, 8'h01));                // 24 zero==0 -> not taken
    put(i_st(3, 8'h23));                     // 25
    expect_st(16'h0023, 16'h0001);
    put(i_br(3'b001, 8'h01));                // 26 carry==0 -> not taken
    put(i_st(3, 8'h24));                     // 27
    expect_st(16'h0024, 16'h0001);
    put(i_li(3, 8'h20));                     // 28
    put(i_alu(6, A_OR, 3));                  // 29 r6 = 0x8020
    put(i_alu(7, A_MOV, 6));                 // 30 jump to 0x8020
    put(i_st(3, 8'h31));                     // 31
    put(i_st(6, 8'h25));                     // 32
    expect_st(16'h0025, 16'h8020);
    put(i_li(3, 8'h03));                     // 33
    put(i_li(2, 8'h01));                     // 34
    put(i_alu(3, A_SUB, 2));                 // 35
    put(i_br(3'b010, 8'hFE));                // 36 zero==0 -> back to 35
    put(i_st(3, 8'h26));                     // 37
    expect_st(16'h0026, 16'h0000);
    put(16'hFFFF);                           // 38 illegal

    tick();
    tick();
    chk("rst_address", bus.address, 16'h0000);
    chk("rst_write", bus.write, 1'b0);
    chk("rst_data_out", bus.data_out, 16'h0000);

    reset = 1'b0;
    tick();
    chk("fetch_not_yet", bus.address, 16'h0000);
    tick();
    chk("first_fetch", bus.address, 16'h8000);
    repeat (8) tick();
    chk("add_store_write", bus.write, 1'b1);
    chk("add_store_addr", bus.address, 16'h0020);
    chk("add_store_data", bus.data_out, 16'h0008);

    // Program for the pass after the illegal-opcode restart: registers must survive
    rom[0] = i_st(4, 8'h28);
    rom[1] = i_st(0, 8'h29);
    rom[2] = i_st(6, 8'h2A);
    rom[3] = i_st(1, 8'h2B);
    expect_st(16'h0028, 16'h1234);
    expect_st(16'h0029, 16'h0008);
    expect_st(16'h002A, 16'h8020);

    tick();
    wait_bus(16'h0013, 1'b1, 40, found);
    chk("stx_seen", found, 1'b1);
    chk("stx_data", bus.data_out, 16'h1234);
    bus.ready = 1'b0;
    high = 1;
    repeat (4) begin
      tick();
      if (bus.write === 1'b1) high++;
    end
    chk("stx_hold_addr", bus.address, 16'h0013);
    chk("stx_hold_data", bus.data_out, 16'h1234);
    chk("stx_ram_untouched", ram[8'h13], 16'h0000);
    bus.ready = 1'b1;
    tick();
    if (bus.write === 1'b1) high++;
    chk("stx_write_cycles", high, 5);
    chk("stx_write_drop", bus.write, 1'b0);
    chk("ram_13", ram[8'h13], 16'h1234);

    wait_bus(16'h8000, 1'b0, 400, found);
    chk("illegal_restart", found, 1'b1);

    wait_bus(16'h002B, 1'b1, 40, found);
    chk("st_stall_seen", found, 1'b1);
    chk("st_stall_data", bus.data_out, 16'h0010);
    bus.ready = 1'b0;
    tick();
    tick();
    chk("st_stall_held", bus.write, 1'b1);
    reset = 1'b1;
    tick();
    chk("rst_stall_write", bus.write, 1'b0);
    chk("rst_stall_address", bus.address, 16'h0000);
    chk("rst_stall_data_out", bus.data_out, 16'h0000);
    reset     = 1'b0;
    bus.ready = 1'b1;
    tick();
    tick();
    chk("rst_restart_fetch", bus.address, 16'h8000);
    chk("ram_2b_untouched", ram[8'h2B], 16'h0000);
    reset = 1'b1;
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
